control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/control_unit_if.sv | 24 ++
 rtl/control_unit_op_decode.sv | 27 ++
 rtl/control_unit.sv | 133 +++++++++++++
 tb/tb_control_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: controller state codes, opcodes, ALU op codes and
// the opcode-class type produced by op_decode.
package cpu_pkg;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [4:0] OP_R_LO = 5'b00011;
    localparam logic [4:0] OP_R_HI = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_RALU,
        CLS_IALU,
        CLS_BR,
        CLS_HALT
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [4:0] alu_op;
    } op_info_t;

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing bundle of the control unit: instruction/condition in,
// register-transfer strobes and ALU operation out.
interface control_unit_if #(parameter int OPW = 5);
    logic [31:0]    IR;
    logic           CON;
    logic           PCout, Zlowout, Zhighout, MDRout, Cout;
    logic           MARin, PCin, MDRin, IRin, Yin, Zin;
    logic           IncPC, Read, Gra, Grb, Grc, Rin, Rout, CONin;
    logic [OPW-1:0] operation;

    modport master (
        input  IR, CON,
        output PCout, Zlowout, Zhighout, MDRout, Cout, MARin, PCin, MDRin,
               IRin, Yin, Zin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, CONin,
               operation
    );

    modport slave (
        output IR, CON,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, MARin, PCin, MDRin,
               IRin, Yin, Zin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, CONin,
               operation
    );
endinterface

// File: rtl/control_unit_op_decode.sv
// Opcode-class decode: sorts IR[31:27] into R-ALU / I-ALU / br / halt / nop
// and picks the ALU operation the execute phase will request.
module op_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_info_t   info_o
);
    always_comb begin
        info_o.cls    = CLS_NOP;
        info_o.alu_op = 5'b00000;
        if (opcode_i >= OP_R_LO && opcode_i <= OP_R_HI) begin
            info_o.cls    = CLS_RALU;
            info_o.alu_op = opcode_i;
        end else begin
            case (opcode_i)
                OP_ADDI: begin info_o.cls = CLS_IALU; info_o.alu_op = ALU_ADD; end
                OP_ANDI: begin info_o.cls = CLS_IALU; info_o.alu_op = ALU_AND; end
                OP_ORI:  begin info_o.cls = CLS_IALU; info_o.alu_op = ALU_OR;  end
                // branch target is PC + C, so it borrows the adder
                OP_BR:   begin info_o.cls = CLS_BR;   info_o.alu_op = ALU_ADD; end
                OP_HALT: info_o.cls = CLS_HALT;
                default: info_o.cls = CLS_NOP;
            endcase
        end
    end
endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T6, IDLE and HALT.
// Optional CU_SINGLE_STEP_EN adds a step input and returns to IDLE after
// every instruction.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic stop,
`ifdef CU_SINGLE_STEP_EN
    input  logic step,
`endif
    output logic halted,
    control_unit_if.master dp
);
    logic [3:0] state_q, state_d;
    logic [3:0] fin_state;
    logic       start;
    op_info_t   info;

    op_decode u_dec (
        .opcode_i (dp.IR[31:27]),
        .info_o   (info)
    );

`ifdef CU_SINGLE_STEP_EN
    assign start     = (run | step) & ~stop;
    assign fin_state = S_IDLE;
`else
    assign start     = run & ~stop;
    assign fin_state = stop ? S_IDLE : S_T0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (info.cls)
                    CLS_RALU, CLS_IALU, CLS_BR: state_d = S_T4;
                    CLS_HALT:                   state_d = S_HALT;
                    default:                    state_d = fin_state;
                endcase
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (info.cls == CLS_BR) ? S_T6 : fin_state;
            S_T6:   state_d = fin_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Strobes are a pure decode of state_q, so clr clears them without a clock.
    always_comb begin
        dp.PCout     = 1'b0;
        dp.Zlowout   = 1'b0;
        dp.Zhighout  = 1'b0;
        dp.MDRout    = 1'b0;
        dp.Cout      = 1'b0;
        dp.MARin     = 1'b0;
        dp.PCin      = 1'b0;
        dp.MDRin     = 1'b0;
        dp.IRin      = 1'b0;
        dp.Yin       = 1'b0;
        dp.Zin       = 1'b0;
        dp.IncPC     = 1'b0;
        dp.Read      = 1'b0;
        dp.Gra       = 1'b0;
        dp.Grb       = 1'b0;
        dp.Grc       = 1'b0;
        dp.Rin       = 1'b0;
        dp.Rout      = 1'b0;
        dp.CONin     = 1'b0;
        dp.operation = '0;
        case (state_q)
            S_T0: begin
                dp.PCout = 1'b1; dp.MARin = 1'b1; dp.IncPC = 1'b1; dp.Zin = 1'b1;
            end
            S_T1: begin
                dp.Zlowout = 1'b1; dp.PCin = 1'b1; dp.Read = 1'b1; dp.MDRin = 1'b1;
            end
            S_T2: begin
                dp.MDRout = 1'b1; dp.IRin = 1'b1;
            end
            S_T3: begin
                if (info.cls == CLS_RALU || info.cls == CLS_IALU) begin
                    dp.Grb = 1'b1; dp.Rout = 1'b1; dp.Yin = 1'b1;
                end else if (info.cls == CLS_BR) begin
                    dp.Gra = 1'b1; dp.Rout = 1'b1; dp.CONin = 1'b1;
                end
            end
            S_T4: begin
                if (info.cls == CLS_RALU) begin
                    dp.Grc = 1'b1; dp.Rout = 1'b1; dp.Zin = 1'b1;
                    dp.operation = OPW'(info.alu_op);
                end else if (info.cls == CLS_IALU) begin
                    dp.Cout = 1'b1; dp.Zin = 1'b1;
                    dp.operation = OPW'(info.alu_op);
                end else if (info.cls == CLS_BR) begin
                    dp.PCout = 1'b1; dp.Yin = 1'b1;
                end
            end
            S_T5: begin
                if (info.cls == CLS_RALU || info.cls == CLS_IALU) begin
                    dp.Zlowout = 1'b1; dp.Gra = 1'b1; dp.Rin = 1'b1;
                end else if (info.cls == CLS_BR) begin
                    dp.Cout = 1'b1; dp.Zin = 1'b1;
                    dp.operation = OPW'(info.alu_op);
                end
            end
            S_T6: begin
                if (info.cls == CLS_BR && dp.CON) begin
                    dp.Zlowout = 1'b1; dp.PCin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus random
// instructions compared per cycle against a queue of expected strobe words.
module tb_control_unit;
    typedef logic [24:0] word_t;

    localparam word_t M_HALTED   = word_t'(1);
    localparam word_t M_CONIN    = word_t'(1) << 6;
    localparam word_t M_ROUT     = word_t'(1) << 7;
    localparam word_t M_RIN      = word_t'(1) << 8;
    localparam word_t M_GRC      = word_t'(1) << 9;
    localparam word_t M_GRB      = word_t'(1) << 10;
    localparam word_t M_GRA      = word_t'(1) << 11;
    localparam word_t M_READ     = word_t'(1) << 12;
    localparam word_t M_INCPC    = word_t'(1) << 13;
    localparam word_t M_ZIN      = word_t'(1) << 14;
    localparam word_t M_YIN      = word_t'(1) << 15;
    localparam word_t M_IRIN     = word_t'(1) << 16;
    localparam word_t M_MDRIN    = word_t'(1) << 17;
    localparam word_t M_PCIN     = word_t'(1) << 18;
    localparam word_t M_MARIN    = word_t'(1) << 19;
    localparam word_t M_COUT     = word_t'(1) << 20;
    localparam word_t M_MDROUT   = word_t'(1) << 21;
    localparam word_t M_ZLOWOUT  = word_t'(1) << 23;
    localparam word_t M_PCOUT    = word_t'(1) << 24;

`ifdef CU_SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    logic clk, clr, run, stop, halted;
`ifdef CU_SINGLE_STEP_EN
    logic step;
`endif
    int n_chk = 0;
    int n_err = 0;
    word_t expq[$];

    control_unit_if #(.OPW(5)) dp();

    control_unit #(.OPW(5)) dut (
        .clk    (clk),
        .clr    (clr),
        .run    (run),
        .stop   (stop),
`ifdef CU_SINGLE_STEP_EN
        .step   (step),
`endif
        .halted (halted),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t obs();
        return {dp.PCout, dp.Zlowout, dp.Zhighout, dp.MDRout, dp.Cout, dp.MARin,
                dp.PCin, dp.MDRin, dp.IRin, dp.Yin, dp.Zin, dp.IncPC, dp.Read,
                dp.Gra, dp.Grb, dp.Grc, dp.Rin, dp.Rout, dp.CONin,
                dp.operation, halted};
    endfunction

    function automatic word_t opw(int v);
        return word_t'(v) << 1;
    endfunction

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Expected strobe word per cycle, T0 through the instruction's last state.
    task automatic build(input logic [4:0] op, input bit con);
        expq.delete();
        expq.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        expq.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
        expq.push_back(M_MDROUT | M_IRIN);
        if (op >= 3 && op <= 11) begin
            expq.push_back(M_GRB | M_ROUT | M_YIN);
            expq.push_back(M_GRC | M_ROUT | M_ZIN | opw(int'(op)));
            expq.push_back(M_ZLOWOUT | M_GRA | M_RIN);
        end else if (op >= 12 && op <= 14) begin
            expq.push_back(M_GRB | M_ROUT | M_YIN);
            expq.push_back(M_COUT | M_ZIN | opw(op == 12 ? 3 : (op == 13 ? 5 : 6)));
            expq.push_back(M_ZLOWOUT | M_GRA | M_RIN);
        end else if (op == 19) begin
            expq.push_back(M_GRA | M_ROUT | M_CONIN);
            expq.push_back(M_PCOUT | M_YIN);
            expq.push_back(M_COUT | M_ZIN | opw(3));
            expq.push_back(con ? (M_ZLOWOUT | M_PCIN) : word_t'(0));
        end else begin
            expq.push_back(word_t'(0));
        end
    endtask

    // Starts from IDLE; run/stop are randomised where they must be ignored.
    task automatic run_instr(input logic [31:0] ir, input bit con, input bit stop_last);
        logic [4:0] op;
        int last;
        op = ir[31:27];
        build(op, con);
        last = expq.size() - 1;
        @(negedge clk);
        check($sformatf("idle_before_op%0d", op), obs(), word_t'(0));
        dp.IR = ir; dp.CON = con; run = 1'b1; stop = 1'b0;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            check($sformatf("op%0d_con%0d_T%0d", op, con, i), obs(), expq[i]);
            run  = (i == last) ? 1'b0 : 1'($urandom_range(0, 1));
            stop = (i == last) ? stop_last : 1'($urandom_range(0, 1));
        end
        if (!stop_last && !SS && op != 5'd27) begin
            for (int i = 0; i <= last; i++) begin
                @(negedge clk);
                check($sformatf("op%0d_refetch_T%0d", op, i), obs(), expq[i]);
                run  = 1'b0;
                stop = (i == last);
            end
        end
    endtask

    initial begin
        logic [4:0] rop;
        clr = 1'b0; run = 1'b0; stop = 1'b0; dp.IR = '0; dp.CON = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step = 1'b0;
`endif
        #3 check("reset", obs(), word_t'(0));
        @(negedge clk); clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_run", obs(), word_t'(0));
        end
        run = 1'b1; stop = 1'b1;
        @(negedge clk);
        check("idle_run_with_stop", obs(), word_t'(0));
        run = 1'b0; stop = 1'b0;

        run_instr(32'h18918000, 1'b0, 1'b0);
        run_instr(32'h18918000, 1'b0, 1'b1);
        run_instr(32'h60900010, 1'b0, 1'b1);
        run_instr(32'h99000005, 1'b1, 1'b1);
        run_instr(32'h99000005, 1'b0, 1'b1);
        run_instr(32'hD0000000, 1'b0, 1'b1);

        repeat (30) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'd27) rop = 5'd26;
            run_instr({rop, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        // asynchronous clear in the middle of an add
        @(negedge clk);
        dp.IR = 32'h18918000; run = 1'b1; stop = 1'b0;
        @(negedge clk); run = 1'b0;
        repeat (4) @(negedge clk);
        check("add_T4_before_clr", obs(), M_GRC | M_ROUT | M_ZIN | opw(3));
        #1 clr = 1'b0;
        #1 check("clr_mid_T4", obs(), word_t'(0));
        @(negedge clk); clr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_after_clr", obs(), word_t'(0));
        end

        run_instr(32'hD8000000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("halt_hold_%0d", i), obs(), M_HALTED);
            run = ~run;
        end
        #1 clr = 1'b0;
        #1 check("halt_clr", obs(), word_t'(0));
        @(negedge clk); clr = 1'b1; run = 1'b0;
        @(negedge clk);
        check("idle_after_halt", obs(), word_t'(0));

`ifdef CU_SINGLE_STEP_EN
        build(5'd26, 1'b0);
        dp.IR = 32'hD0000000; step = 1'b1;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge clk);
            check($sformatf("step_nop_T%0d", i), obs(), expq[i]);
            step = 1'b0;
        end
        repeat (2) begin
            @(negedge clk);
            check("step_back_to_idle", obs(), word_t'(0));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
